fpga2_receiver: RTL and testbench

//  FPGA-2 end of the inter-FPGA burst link. Answers the FPGA-1 sender's req/rdy/ack handshake,

---
 rtl/fpga2_receiver.sv | 227 ++++++++++++++++++++++
 tb/tb_fpga2_receiver.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga2_receiver.sv
// rtl/fpga2_receiver.sv - FPGA-2 burst link receiver with commit/rollback FIFO
//
// Purpose: answers the FPGA-1 sender's req/rdy/ack handshake, captures a burst
// of words into a FIFO at a speculative write pointer, checks the word count
// on send_done, then commits (ACK) or rolls back (NACK by holding rdy low).
// The local process drains committed words only.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_in          request from FPGA 1
//   valid_in        data_in carries a word this cycle
//   data_in         data word from FPGA 1
//   send_done_in    end of burst (stretched pulse, edge-detected here)
//   exp_count       expected words per burst, latched on IDLE->RECV
//   rdy_out         ready to FPGA 1
//   ack_out         burst accepted, to FPGA 1
//   rd_en           FIFO pop request from the local process
//   rd_data         popped word (registered)
//   rd_valid        rd_data valid, one cycle after an accepted pop
//   empty_o         no committed words
//   level_o         committed word count
//   burst_ok        one-cycle pulse per committed burst
//   err_count       failed/aborted bursts, saturating
module fpga2_receiver #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int CNT_W       = 10,
  parameter int NACK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              send_done_in,
  input  logic [CNT_W-1:0]  exp_count,
  output logic              rdy_out,
  output logic              ack_out,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              burst_ok,
  output logic [7:0]        err_count
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  // Wide enough to compare free space (0..DEPTH) against any exp_count.
  localparam int CMP_W = ((PTR_W > CNT_W) ? PTR_W : CNT_W) + 1;
  localparam int NC_W  = $clog2(NACK_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_CHECK = 3'd2,
    S_ACK   = 3'd3,
    S_NACK  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wp_s_q, wp_s_d;
  logic [PTR_W-1:0]  wp_c_q, wp_c_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              ovf_q, ovf_d;
  logic              sd_q;
  logic [NC_W-1:0]   nack_cnt_q, nack_cnt_d;
  logic [7:0]        err_q, err_d, err_inc;
  logic              rdy_q, ack_q, burst_ok_q, rd_valid_q, empty_q;
  logic [PTR_W-1:0]  level_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  used_s;
  logic [CMP_W-1:0]  free_w, exp_w;
  logic              sd_rise, pop, pass, wr_en, commit;

  always_comb begin
    // Free space is measured against the speculative pointer so a burst can
    // never overwrite committed-but-unread words.
    used_s  = wp_s_q - rd_ptr_q;
    free_w  = CMP_W'(DEPTH) - CMP_W'(used_s);
    exp_w   = CMP_W'(exp_count);
    sd_rise = send_done_in && !sd_q;
    // Pops use the registered empty flag, which tracks wp_c only.
    pop     = rd_en && !empty_q;
    pass    = !ovf_q && (word_cnt_q == exp_q);
    err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    wp_s_d     = wp_s_q;
    wp_c_d     = wp_c_q;
    exp_d      = exp_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    nack_cnt_d = nack_cnt_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

    unique case (state_q)
      S_IDLE: begin
        if (req_in && (free_w >= exp_w)) begin
          exp_d      = exp_count;
          word_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = S_RECV;
        end
      end
      S_RECV: begin
        if (!req_in) begin
          // Sender abandoned the burst: discard everything written so far.
          wp_s_d  = wp_c_q;
          err_d   = err_inc;
          state_d = S_IDLE;
        end else begin
          if (valid_in) begin
            if (free_w != '0) begin
              wr_en  = 1'b1;
              wp_s_d = wp_s_q + PTR_W'(1);
              if (word_cnt_q != '1) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
              end
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (sd_rise) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (pass) begin
          wp_c_d  = wp_s_q;
          commit  = 1'b1;
          state_d = S_ACK;
        end else begin
          wp_s_d     = wp_c_q;
          err_d      = err_inc;
          nack_cnt_d = NC_W'(NACK_CYCLES - 1);
          state_d    = S_NACK;
        end
      end
      S_ACK: begin
        if (!req_in) begin
          state_d = S_IDLE;
        end
      end
      S_NACK: begin
        if (nack_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          nack_cnt_d = nack_cnt_q - NC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wp_s_q     <= '0;
      wp_c_q     <= '0;
      rd_ptr_q   <= '0;
      exp_q      <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      sd_q       <= 1'b0;
      nack_cnt_q <= '0;
      err_q      <= '0;
      rdy_q      <= 1'b0;
      ack_q      <= 1'b0;
      burst_ok_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wp_s_q     <= wp_s_d;
      wp_c_q     <= wp_c_d;
      rd_ptr_q   <= rd_ptr_d;
      exp_q      <= exp_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      sd_q       <= send_done_in;
      nack_cnt_q <= nack_cnt_d;
      err_q      <= err_d;
      // Handshake outputs are registered from the next state so they line up
      // with the state they describe.
      rdy_q      <= (state_d == S_RECV) || (state_d == S_CHECK) || (state_d == S_ACK);
      ack_q      <= (state_d == S_ACK);
      burst_ok_q <= commit;
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
      end
      level_q    <= wp_c_d - rd_ptr_d;
      empty_q    <= (wp_c_d == rd_ptr_d);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_s_q[ADDR_W-1:0]] <= data_in;
    end
  end

  assign rdy_out   = rdy_q;
  assign ack_out   = ack_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;
  assign burst_ok  = burst_ok_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_fpga2_receiver.sv
// tb/tb_fpga2_receiver.sv - scoreboard testbench for fpga2_receiver
module tb_fpga2_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        send_done_in = 1'b0;
  logic [9:0]  exp_count = '0;
  logic        rdy_out, ack_out;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid, empty_o, burst_ok;
  logic [9:0]  level_o;
  logic [7:0]  err_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  fpga2_receiver #(
    .DATA_W(32), .ADDR_W(9), .CNT_W(10), .NACK_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .valid_in(valid_in), .data_in(data_in),
    .send_done_in(send_done_in), .exp_count(exp_count), .rdy_out(rdy_out),
    .ack_out(ack_out), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty_o(empty_o), .level_o(level_o), .burst_ok(burst_ok), .err_count(err_count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic open_burst(input int expc, output int waited);
    exp_count = expc[9:0];
    req_in    = 1'b1;
    waited    = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (rdy_out !== 1'b1 && waited < 2000);
    n_checks++;
    if (rdy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL open_burst: rdy_out=%b after %0d cycles, required 1", rdy_out, waited);
    end
  endtask

  task automatic send_words(input int n, input logic [31:0] base, input bit push);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in  = base + 32'(i);
      if (push) expq.push_back(base + 32'(i));
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  task automatic finish_burst(input bit ok, input int lvl, input int errc);
    send_done_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rdy_out !== 1'b1) begin
      n_fail++; $display("FAIL check_rdy: rdy_out=%b required 1", rdy_out);
    end
    @(negedge clk);
    if (ok) begin
      n_checks++;
      if (ack_out !== 1'b1) begin
        n_fail++; $display("FAIL ack_high: ack_out=%b required 1", ack_out);
      end
      n_checks++;
      if (burst_ok !== 1'b1) begin
        n_fail++; $display("FAIL burst_ok_pulse: burst_ok=%b required 1", burst_ok);
      end
    end else begin
      n_checks++;
      if (rdy_out !== 1'b0 || ack_out !== 1'b0) begin
        n_fail++; $display("FAIL nack_entry: rdy_out=%b ack_out=%b required 0 0", rdy_out, ack_out);
      end
    end
    n_checks++;
    if (err_count !== errc[7:0]) begin
      n_fail++; $display("FAIL err_count: got %0d required %0d", err_count, errc);
    end
    if (lvl >= 0) begin
      n_checks++;
      if (level_o !== lvl[9:0]) begin
        n_fail++; $display("FAIL level_after_check: got %0d required %0d", level_o, lvl);
      end
    end
    @(negedge clk);
    send_done_in = 1'b0;
    if (ok) begin
      n_checks++;
      if (burst_ok !== 1'b0) begin
        n_fail++; $display("FAIL burst_ok_single: burst_ok=%b required 0", burst_ok);
      end
      req_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ack_out !== 1'b0) begin
        n_fail++; $display("FAIL ack_release: ack_out=%b required 0", ack_out);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (rdy_out !== 1'b0) begin
          n_fail++; $display("FAIL nack_rdy_low: cycle %0d rdy_out=%b required 0", k + 2, rdy_out);
        end
        if (k < 2) @(negedge clk);
      end
    end
  endtask

  task automatic pop_n(input int n);
    logic [31:0] exp_w;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == n - 1) rd_en = 1'b0;
      exp_w = (expq.size() != 0) ? expq.pop_front() : 32'hDEADBEEF;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_w) begin
        n_fail++;
        $display("FAIL pop_data[%0d]: rd_valid=%b rd_data=%h required 1 %h", i, rd_valid, rd_data, exp_w);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rdy_out !== 1'b0 || ack_out !== 1'b0 || rd_valid !== 1'b0 || burst_ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: rdy=%b ack=%b rd_valid=%b burst_ok=%b required 0000",
                         rdy_out, ack_out, rd_valid, burst_ok);
    end
    n_checks++;
    if (rd_data !== 32'd0 || level_o !== 10'd0 || err_count !== 8'd0 || empty_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_data: rd_data=%h level=%0d err=%0d empty=%b required 0 0 0 1",
                         rd_data, level_o, err_count, empty_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int w;
    open_burst(4, w);
    n_checks++;
    if (w != 1) begin
      n_fail++; $display("FAIL rdy_latency: got %0d cycles required 1", w);
    end
    send_words(4, 32'hA0, 1'b1);
    finish_burst(1'b1, 4, 0);
    pop_n(4);
    n_checks++;
    if (empty_o !== 1'b1 || level_o !== 10'd0) begin
      n_fail++; $display("FAIL basic_drained: empty=%b level=%0d required 1 0", empty_o, level_o);
    end
  endtask

  task automatic test_nack_resend;
    int w;
    open_burst(4, w);
    send_words(3, 32'hB0, 1'b0);
    finish_burst(1'b0, 0, 1);
    open_burst(4, w);
    send_words(4, 32'hB0, 1'b1);
    finish_burst(1'b1, 4, 1);
    pop_n(4);
  endtask

  task automatic test_abort;
    int w;
    open_burst(4, w);
    send_words(2, 32'hC8, 1'b0);
    req_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy_out !== 1'b0 || ack_out !== 1'b0) begin
      n_fail++; $display("FAIL abort_handshake: rdy=%b ack=%b required 0 0", rdy_out, ack_out);
    end
    n_checks++;
    if (err_count !== 8'd2 || level_o !== 10'd0) begin
      n_fail++; $display("FAIL abort_state: err=%0d level=%0d required 2 0", err_count, level_o);
    end
    open_burst(4, w);
    send_words(4, 32'hC0, 1'b1);
    finish_burst(1'b1, 4, 2);
    pop_n(4);
  endtask

  task automatic test_empty_burst;
    int w;
    open_burst(0, w);
    finish_burst(1'b1, 0, 2);
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_fail++; $display("FAIL empty_burst_commit: empty=%b required 1", empty_o);
    end
  endtask

  task automatic test_underflow;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0 || empty_o !== 1'b1 || level_o !== 10'd0) begin
        n_fail++; $display("FAIL underflow: rd_valid=%b empty=%b level=%0d required 0 1 0",
                           rd_valid, empty_o, level_o);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_full;
    int w;
    open_burst(510, w);
    send_words(510, 32'h1000, 1'b1);
    finish_burst(1'b1, 510, 2);
    exp_count = 10'd4;
    req_in    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rdy_out !== 1'b0) begin
        n_fail++; $display("FAIL backpressure: cycle %0d rdy_out=%b required 0", i, rdy_out);
      end
    end
    pop_n(2);
    open_burst(4, w);
    send_words(4, 32'h2000, 1'b1);
    finish_burst(1'b1, 512, 2);
    pop_n(512);
    n_checks++;
    if (empty_o !== 1'b1 || level_o !== 10'd0) begin
      n_fail++; $display("FAIL full_drained: empty=%b level=%0d required 1 0", empty_o, level_o);
    end
  endtask

  task automatic test_back_to_back;
    int          w;
    int          popped, early;
    bit          seen_ack;
    logic        prev_empty;
    logic [31:0] exp_w;
    open_burst(2, w);
    send_words(2, 32'hD0, 1'b1);
    finish_burst(1'b1, 2, 2);
    popped = 0; early = 0; seen_ack = 1'b0;
    fork
      begin
        open_burst(4, w);
        send_words(4, 32'hE0, 1'b1);
        finish_burst(1'b1, -1, 2);
      end
      begin
        rd_en = 1'b1;
        prev_empty = empty_o;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (rd_valid === 1'b1) begin
            n_checks++;
            if (prev_empty !== 1'b0) begin
              n_fail++; $display("FAIL rd_valid_while_empty: cycle %0d prev empty=%b required 0", c, prev_empty);
            end
            exp_w = (expq.size() != 0) ? expq.pop_front() : 32'hDEADBEEF;
            n_checks++;
            if (rd_data !== exp_w) begin
              n_fail++; $display("FAIL concurrent_pop: rd_data=%h required %h", rd_data, exp_w);
            end
            popped++;
            if (!seen_ack) early++;
          end
          if (ack_out === 1'b1) seen_ack = 1'b1;
          prev_empty = empty_o;
        end
        rd_en = 1'b0;
      end
    join
    n_checks++;
    if (popped != 6 || early > 2) begin
      n_fail++; $display("FAIL concurrent_counts: popped=%0d early=%0d required 6 <=2", popped, early);
    end
    n_checks++;
    if (empty_o !== 1'b1 || level_o !== 10'd0 || expq.size() != 0) begin
      n_fail++; $display("FAIL concurrent_end: empty=%b level=%0d queue=%0d required 1 0 0",
                         empty_o, level_o, expq.size());
    end
  endtask

  task automatic test_reset_mid;
    int w;
    for (int ph = 0; ph < 2; ph++) begin
      open_burst(4, w);
      send_words((ph == 0) ? 4 : 1, 32'hF0, 1'b0);
      if (ph == 0) begin
        send_done_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ack_out !== 1'b1) begin
          n_fail++; $display("FAIL pre_reset_ack: ack_out=%b required 1", ack_out);
        end
      end
      rst = 1'b1; req_in = 1'b0; send_done_in = 1'b0; valid_in = 1'b0;
      expq.delete();
      @(negedge clk);
      n_checks++;
      if (rdy_out !== 1'b0 || ack_out !== 1'b0 || rd_valid !== 1'b0 || burst_ok !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_ctrl[%0d]: rdy=%b ack=%b rd_valid=%b burst_ok=%b required 0000",
                           ph, rdy_out, ack_out, rd_valid, burst_ok);
      end
      n_checks++;
      if (rd_data !== 32'd0 || level_o !== 10'd0 || err_count !== 8'd0 || empty_o !== 1'b1) begin
        n_fail++; $display("FAIL mid_reset_data[%0d]: rd_data=%h level=%0d err=%0d empty=%b required 0 0 0 1",
                           ph, rd_data, level_o, err_count, empty_o);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nack_resend();
    test_abort();
    test_empty_burst();
    test_underflow();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
